// File: rtl/seg_display_pkg.sv
// Shared constants and helpers for the seven-segment display controller.
package seg_display_pkg;

  // Code that the decoder renders as an all-dark digit.
  localparam logic [3:0] BLANK_CODE = 4'hF;

  // Decoder output for BLANK_CODE: active-low segments with the dp off.
  localparam logic [7:0] BLANK_SEG = 8'hFF;

  localparam int unsigned DEFAULT_BLINK_DIV = 25_000_000;
  localparam int unsigned DEFAULT_SCAN_DIV  = 50_000;

  // Widest display the leading-zero helper supports.
  localparam int unsigned LZB_MAX_DIGITS = 32;

  // dead[j] = digit j is disabled or holds zero. Digit idx is a leading zero
  // when it is not digit 0 and it and every digit above it are dead.
  function automatic logic lz_blank(input logic [LZB_MAX_DIGITS-1:0] dead,
                                    input int unsigned idx,
                                    input int unsigned num_digits);
    logic blank;
    blank = (idx != 0);
    for (int unsigned j = 0; j < LZB_MAX_DIGITS; j++) begin
      if (j >= idx && j < num_digits && !dead[j]) blank = 1'b0;
    end
    return blank;
  endfunction

endpackage

// File: rtl/bcd_7_seg.sv
// BCD to seven-segment decoder, active-low segments {dp,g,f,e,d,c,b,a}.
// Codes A-E show A,b,C,d,E; code F is blank.
module bcd_7_seg (
  input  logic [3:0] bcd,
  output logic [7:0] seg
);

  // Pure lookup; dp is always off.
  always_comb begin
    seg = 8'hFF;
    case (bcd)
      4'h0: seg = 8'hC0;
      4'h1: seg = 8'hF9;
      4'h2: seg = 8'hA4;
      4'h3: seg = 8'hB0;
      4'h4: seg = 8'h99;
      4'h5: seg = 8'h92;
      4'h6: seg = 8'h82;
      4'h7: seg = 8'hF8;
      4'h8: seg = 8'h80;
      4'h9: seg = 8'h90;
      4'hA: seg = 8'h88;
      4'hB: seg = 8'h83;
      4'hC: seg = 8'hC6;
      4'hD: seg = 8'hA1;
      4'hE: seg = 8'h86;
      default: seg = 8'hFF;
    endcase
  end

endmodule

// File: rtl/seg_scan_timer.sv
// Prescaled index counter: every DIV cycles the index advances (wrapping at
// NUM_DIGITS-1) and guard is high for the single cycle following the wrap.
module seg_scan_timer #(
  parameter int unsigned DIV        = 50_000,
  parameter int unsigned NUM_DIGITS = 4
) (
  input  logic                          clk,
  input  logic                          rstn,
  output logic [$clog2(NUM_DIGITS)-1:0] index,
  output logic                          guard
);

  localparam int unsigned CNT_W = $clog2(DIV);
  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0] cnt;

  // Prescaler, index advance and one-cycle guard pulse on wrap.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt   <= '0;
      index <= '0;
      guard <= 1'b0;
    end else if (cnt == CNT_LAST) begin
      cnt   <= '0;
      guard <= 1'b1;
      index <= (index == IDX_LAST) ? '0 : index + 1'b1;
    end else begin
      cnt   <= cnt + 1'b1;
      guard <= 1'b0;
    end
  end

endmodule

// File: rtl/seg_display_ctrl.sv
// N-digit BCD seven-segment controller: captured digits with per-digit
// enable/blink, live leading-zero blanking, static and scanned outputs.
module seg_display_ctrl
  import seg_display_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned BLINK_DIV  = DEFAULT_BLINK_DIV,
  parameter int unsigned SCAN_DIV   = DEFAULT_SCAN_DIV,
  parameter bit          MUX_EN     = 1'b1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [NUM_DIGITS-1:0]   blink_en,
  input  logic                    lzb_en,
  output logic [8*NUM_DIGITS-1:0] seg_static,
  output logic [7:0]              seg_mux,
  output logic [NUM_DIGITS-1:0]   an_mux
);

  logic [4*NUM_DIGITS-1:0]   shadow_digits;
  logic [NUM_DIGITS-1:0]     shadow_en;
  logic [NUM_DIGITS-1:0]     shadow_blink;
  logic [0:0]                blink_idx;
  logic                      blink_phase;
  logic [LZB_MAX_DIGITS-1:0] dead;
  logic [3:0]                eff [NUM_DIGITS];
  logic [8*NUM_DIGITS-1:0]   dec_static;

  // Shadow registers; reset leaves every digit disabled and blank.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shadow_digits <= '1;
      shadow_en     <= '0;
      shadow_blink  <= '0;
    end else if (load) begin
      shadow_digits <= digits_in;
      shadow_en     <= digit_en;
      shadow_blink  <= blink_en;
    end
  end

  // Two-position timer; index 0 (reset) is the visible phase.
  seg_scan_timer #(
    .DIV        (BLINK_DIV),
    .NUM_DIGITS (2)
  ) u_blink_timer (
    .clk   (clk),
    .rstn  (rstn),
    .index (blink_idx),
    .guard ()
  );

  assign blink_phase = ~blink_idx[0];

  // Effective code per digit: enable, then blink, then leading-zero blanking.
  always_comb begin
    dead = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      dead[i] = ~shadow_en[i] | (shadow_digits[4*i +: 4] == 4'h0);
    end
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      eff[i] = shadow_digits[4*i +: 4];
      if (!shadow_en[i]) begin
        eff[i] = BLANK_CODE;
      end else if (shadow_blink[i] && !blink_phase) begin
        eff[i] = BLANK_CODE;
      end else if (lzb_en && lz_blank(dead, i, NUM_DIGITS)) begin
        eff[i] = BLANK_CODE;
      end
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_static_dec
    bcd_7_seg u_dec (
      .bcd (eff[g]),
      .seg (dec_static[8*g +: 8])
    );
  end

  // Registered static segment bus.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      seg_static <= {NUM_DIGITS{BLANK_SEG}};
    end else begin
      seg_static <= dec_static;
    end
  end

  if (MUX_EN) begin : g_mux
    logic [$clog2(NUM_DIGITS)-1:0] scan_idx;
    logic                          scan_guard;
    logic [7:0]                    dec_mux;

    seg_scan_timer #(
      .DIV        (SCAN_DIV),
      .NUM_DIGITS (NUM_DIGITS)
    ) u_scan_timer (
      .clk   (clk),
      .rstn  (rstn),
      .index (scan_idx),
      .guard (scan_guard)
    );

    bcd_7_seg u_dec_mux (
      .bcd (eff[scan_idx]),
      .seg (dec_mux)
    );

    // Registered scan bus; all anodes off during the guard cycle.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        seg_mux <= BLANK_SEG;
        an_mux  <= '1;
      end else if (scan_guard) begin
        seg_mux <= BLANK_SEG;
        an_mux  <= '1;
      end else begin
        seg_mux <= dec_mux;
        an_mux  <= ~(NUM_DIGITS'(1) << scan_idx);
      end
    end
  end else begin : g_no_mux
    assign seg_mux = BLANK_SEG;
    assign an_mux  = '1;
  end

endmodule

// File: doc/seg_display_ctrl.md
Name: seg_display_ctrl

Overview:
Parametrised N-digit BCD seven-segment display controller. It is the successor to the fixed 4-digit visualization path.
- Captures a BCD word on a load strobe.
- Applies per-digit enable, per-digit blinking and optional leading-zero blanking.
- Drives a static per-digit segment bus and a time-multiplexed single-segment/anode scan bus.
- Sits between game/control logic and the board display pins.

Parameters:
NUM_DIGITS, 4, number of BCD digits (>=2)
BLINK_DIV, 25000000, clk cycles per blink half-period (>=2)
SCAN_DIV, 50000, clk cycles each digit is driven in mux mode (>=2)
MUX_EN, 1, 1 = scan outputs active; 0 = seg_mux blank and an_mux all 1

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
load  in  1  capture strobe, sampled on rising clk
digits_in  in  4*NUM_DIGITS  BCD digits, digit i at [4i+3:4i], digit 0 least significant
digit_en  in  NUM_DIGITS  per-digit enable, captured with load
blink_en  in  NUM_DIGITS  per-digit blink select, captured with load
lzb_en  in  1  leading-zero blanking enable, live (not captured)
seg_static  out  8*NUM_DIGITS  decoded segments for digit i at [8i+7:8i]
seg_mux  out  8  decoded segments for the currently scanned digit
an_mux  out  NUM_DIGITS  active-low digit select for the scan bus

Behaviour:
- Reset (async, rstn=0):
  - Shadow digits = 4'hF; shadow digit_en and blink_en = 0.
  - blink_phase = 1 (visible); blink counter = 0.
  - Scan index = 0; scan counter = 0; guard flag = 0.
  - seg_static = BLANK on every digit; seg_mux = BLANK; an_mux = all 1.
  - BLANK is the bcd_7_seg output for code 4'hF.
- Capture: load=1 at edge k latches digits_in, digit_en and blink_en into the shadow registers at edge k. Outputs are registered, so the new data is visible after edge k+1. load held high re-captures every cycle.
- Effective code per digit i, computed combinationally from the shadow registers:
  - 4'hF if digit_en[i]=0.
  - Else 4'hF if blink_en[i]=1 and blink_phase=0.
  - Else 4'hF if lzb_en=1, i!=0, shadow digit i==0, and every higher digit j>i is disabled or zero.
  - Else the shadow digit. Codes 0xA-0xE pass to the decoder unchanged.
  - Digit 0 is never blanked by LZB.
- Blink timer: counter runs 0..BLINK_DIV-1 continuously. On wrap, blink_phase toggles. It runs regardless of load.
- Scan timer (MUX_EN=1):
  - Counter runs 0..SCAN_DIV-1.
  - On wrap, the scan index advances (NUM_DIGITS-1 wraps to 0) and the guard flag is set for exactly one cycle.
  - While guard=1: an_mux = all 1 (anti-ghosting), seg_mux = BLANK.
  - Otherwise: an_mux = ~(1<<index) and seg_mux = decode(effective code of index). Both are registered.
- MUX_EN=0: scan logic is tied off; seg_mux = BLANK and an_mux = all 1 constantly.
- Simultaneous events: load, blink wrap and scan wrap on the same edge all take effect at that edge. The output at k+1 reflects new data, new blink phase and the guard cycle.
- Reset mid-operation: all state returns to reset values immediately. Timers restart from 0 after rstn deasserts, and no load is needed to resume the blank display.
- lzb_en is live: a change is visible on outputs one cycle later.

Decomposition:
- Package seg_display_pkg:
  - BLANK_CODE = 4'hF.
  - Default BLINK_DIV and SCAN_DIV constants.
  - Helper function for leading-zero mask generation.
- Sub-module seg_scan_timer (params DIV, NUM_DIGITS): prescaler counter, scan index and guard pulse. It is also reusable for the blink timer, with NUM_DIGITS=2, index bit 0 used as the phase.
- Decoding reuses the existing bcd_7_seg: NUM_DIGITS instances for the static bus plus one on the mux path.

Test Plan:
(NUM_DIGITS=4, BLINK_DIV=8, SCAN_DIV=4, MUX_EN=1)
- Reset with load=1 asserted -> all seg_static = BLANK, seg_mux = BLANK, an_mux=4'b1111 during and one cycle after reset; load ignored.
- load with digits_in=16'h1234, digit_en=4'hF, blink_en=0 -> after edge k+1, seg_static = decode(4),decode(3),decode(2),decode(1) for digits 0..3.
- Load 16'h0050, lzb_en=1 -> digits 3 and 2 blank, digit 1 = decode(5), digit 0 = decode(0). Toggle lzb_en=0 -> digits 3 and 2 show decode(0) one cycle later.
- blink_en=4'b0001 with 16'h1234 loaded -> digit 0 alternates decode(4)/BLANK every 8 cycles; digits 1-3 are steady.
- Scan run for 20 cycles -> an_mux sequence 1110,1110,1110,1110,1111(guard),1101,... with seg_mux matching the selected digit and BLANK on guard cycles; index wraps 3->0.
- Assert rstn=0 mid-scan at index 2, blink_phase=0 -> immediate return to reset values; after release, an_mux first enables digit 0 and blink_phase=1.
